usb3_ep0in_ctrl: RTL and testbench

Sequencer for the EP0 IN buffer RAM: it loads descriptor and response data into the RAM, then plays it out to the protocol layer as the data stage of a control IN transfer. Playout is split into packets of at most 512 bytes, with last-word byte enables, zero-length-packet (ZLP) generation, retry rewind and abort. It sits between the standard-request/descriptor logic (load side), the 256x32 EP0 IN RAM (registered read, 1-cycle latency) and the USB3 protocol-layer TX path.

---
 rtl/usb3_ep0in_ctrl.sv | 161 ++++++++++++++++
 tb/tb_usb3_ep0in_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_ep0in_ctrl.sv
// EP0 IN buffer sequencer: loads the response into the EP0 IN RAM, then plays it
// out as max-packet-sized data-stage packets with ZLP, retry rewind and abort.
module usb3_ep0in_ctrl #(
  parameter int DEPTH_LOG2 = 8,
  parameter int MAX_PKT    = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buf_wr_en,
  input  logic [31:0]           buf_wr_dat,
  input  logic                  buf_commit,
  input  logic [15:0]           buf_len,
  input  logic [15:0]           wlength,
  input  logic                  abort,
  input  logic                  in_req,
  output logic                  tx_valid,
  output logic [31:0]           tx_data,
  output logic [3:0]            tx_be,
  output logic                  tx_last,
  input  logic                  tx_ready,
  input  logic                  pkt_ack,
  input  logic                  pkt_retry,
  output logic                  ram_wr_we,
  output logic [DEPTH_LOG2-1:0] ram_wr_adr,
  output logic [31:0]           ram_wr_dat,
  output logic [DEPTH_LOG2-1:0] ram_rd_adr,
  input  logic [31:0]           ram_rd_dat,
  output logic                  busy,
  output logic                  done
);
  localparam int AW        = DEPTH_LOG2;
  localparam int TW        = DEPTH_LOG2 + 3;
  localparam int BUF_BYTES = 4 << DEPTH_LOG2;
  localparam logic [TW-1:0] MAXP = TW'(MAX_PKT);

  typedef enum logic [2:0] {IDLE, LOAD, READY, PRIME, STREAM, WAIT_ACK} state_t;
  state_t state, state_n;

  logic [AW:0]   wr_ptr, base, beat_cnt, pkt_words;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] remain, pkt_bytes, total, remain_nxt;
  logic [15:0]   len_cap;
  logic          zlp_pend, zlp_nxt, is_zlp, done_q;
  logic          load_st, wr_ok, accept, last_beat, ack_ok, ack_fin;

  // Transfer length: buffer capacity, bytes loaded and wLength, whichever is smallest.
  always_comb begin
    len_cap = (buf_len > 16'(BUF_BYTES)) ? 16'(BUF_BYTES) : buf_len;
    total   = (len_cap > wlength) ? wlength[TW-1:0] : len_cap[TW-1:0];
  end

  always_comb begin
    pkt_bytes  = (remain > MAXP) ? MAXP : remain;
    pkt_words  = pkt_bytes[TW-1:2] + (AW+1)'(|pkt_bytes[1:0]);
    remain_nxt = remain - pkt_bytes;
    zlp_nxt    = zlp_pend & ~is_zlp;
    ack_ok     = (state == WAIT_ACK) & pkt_ack & ~pkt_retry;
    ack_fin    = ack_ok & (remain_nxt == '0) & ~zlp_nxt;
  end

  // Load port is a straight pass-through; only writes in IDLE/LOAD below the top word land.
  always_comb begin
    load_st    = (state == IDLE) || (state == LOAD);
    wr_ok      = load_st & buf_wr_en & ~wr_ptr[AW] & ~abort & ~reset;
    ram_wr_we  = wr_ok;
    ram_wr_adr = wr_ptr[AW-1:0];
    ram_wr_dat = buf_wr_dat;
  end

  // Read address runs one ahead on acceptance so ram_rd_dat always shows mem[rd_ptr].
  always_comb begin
    tx_valid   = (state == STREAM);
    last_beat  = (beat_cnt == (AW+1)'(1));
    tx_last    = tx_valid & last_beat;
    accept     = tx_valid & tx_ready;
    ram_rd_adr = accept ? rd_ptr + AW'(1) : rd_ptr;
    tx_data    = ram_rd_dat;
    tx_be      = 4'b0000;
    if (tx_valid && !is_zlp) begin
      tx_be = 4'b1111;
      if (last_beat) begin
        case (pkt_bytes[1:0])
          2'd1:    tx_be = 4'b0001;
          2'd2:    tx_be = 4'b0011;
          2'd3:    tx_be = 4'b0111;
          default: tx_be = 4'b1111;
        endcase
      end
    end
    busy = (state != IDLE);
    done = done_q;
  end

  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else begin
      case (state)
        IDLE:     if (buf_commit) state_n = READY;
                  else if (buf_wr_en) state_n = LOAD;
        LOAD:     if (buf_commit) state_n = READY;
        READY:    if (in_req) state_n = PRIME;
        PRIME:    state_n = STREAM;
        STREAM:   if (accept && last_beat) state_n = WAIT_ACK;
        WAIT_ACK: if (pkt_retry) state_n = READY;
                  else if (pkt_ack) state_n = ack_fin ? IDLE : READY;
        default:  state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      base     <= '0;
      beat_cnt <= '0;
      rd_ptr   <= '0;
      remain   <= '0;
      zlp_pend <= 1'b0;
      is_zlp   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort) begin
      wr_ptr   <= '0;
      remain   <= '0;
      zlp_pend <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= ack_fin;
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      case (state)
        IDLE, LOAD: if (buf_commit) begin
          remain   <= total;
          zlp_pend <= (total == '0) ||
                      (((total % MAXP) == '0) && ({{(16-TW){1'b0}}, total} < wlength));
          base     <= '0;
          wr_ptr   <= '0;
        end
        READY: if (in_req) rd_ptr <= base[AW-1:0];
        PRIME: begin
          is_zlp   <= (pkt_bytes == '0);
          beat_cnt <= (pkt_bytes == '0) ? (AW+1)'(1) : pkt_words;
        end
        STREAM: if (accept) begin
          rd_ptr   <= rd_ptr + AW'(1);
          beat_cnt <= beat_cnt - (AW+1)'(1);
        end
        WAIT_ACK: if (ack_ok) begin
          base     <= base + pkt_words;
          remain   <= remain_nxt;
          zlp_pend <= zlp_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_usb3_ep0in_ctrl.sv
// Directed bench for usb3_ep0in_ctrl: vector table of transfers plus retry/abort/reset sequences.
module tb_usb3_ep0in_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        buf_wr_en = 0, buf_commit = 0, abort = 0, in_req = 0;
  logic        tx_ready = 1'b1, pkt_ack = 0, pkt_retry = 0;
  logic [31:0] buf_wr_dat = '0;
  logic [15:0] buf_len = '0, wlength = '0;
  logic        tx_valid, tx_last, ram_wr_we, busy, done;
  logic [31:0] tx_data, ram_wr_dat, ram_rd_dat;
  logic [3:0]  tx_be;
  logic [7:0]  ram_wr_adr, ram_rd_adr;
  logic [31:0] mem [256];
  int checks = 0, failures = 0;

  usb3_ep0in_ctrl dut (
    .clk(clk), .reset(reset), .buf_wr_en(buf_wr_en), .buf_wr_dat(buf_wr_dat),
    .buf_commit(buf_commit), .buf_len(buf_len), .wlength(wlength), .abort(abort),
    .in_req(in_req), .tx_valid(tx_valid), .tx_data(tx_data), .tx_be(tx_be),
    .tx_last(tx_last), .tx_ready(tx_ready), .pkt_ack(pkt_ack), .pkt_retry(pkt_retry),
    .ram_wr_we(ram_wr_we), .ram_wr_adr(ram_wr_adr), .ram_wr_dat(ram_wr_dat),
    .ram_rd_adr(ram_rd_adr), .ram_rd_dat(ram_rd_dat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_we) mem[ram_wr_adr] <= ram_wr_dat;
    ram_rd_dat <= mem[ram_rd_adr];
  end

  typedef struct {
    int len; int wl; int nload;
    int p0; logic [3:0] b0;
    int p1; logic [3:0] b1;
    bit zlp; bit tog;
  } vec_t;
  vec_t tv [9];

  function automatic logic [31:0] wv(input int seed, input int i);
    logic [7:0] s, w;
    s = seed[7:0];
    w = i[7:0];
    return {s, w, ~w, (i >= 256) ? 8'hE7 : 8'h3C};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int seed, input int n);
    for (int i = 0; i < n; i++) begin
      buf_wr_en  = 1'b1;
      buf_wr_dat = wv(seed, i);
      if (i == 0) begin
        #1;
        chk("first_wr_adr", ram_wr_adr, 0);
        chk("first_wr_we", ram_wr_we, 1);
      end
      tick();
    end
    buf_wr_en = 1'b0;
  endtask

  task automatic commit(input int len, input int wl);
    buf_commit = 1'b1;
    buf_len    = 16'(len);
    wlength    = 16'(wl);
    tick();
    buf_commit = 1'b0;
    chk("busy_after_commit", busy, 1);
  endtask

  task automatic req();
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
  endtask

  task automatic ack(input bit retry, input bit both, input bit exp_done);
    pkt_ack   = !retry || both;
    pkt_retry = retry;
    tick();
    pkt_ack   = 1'b0;
    pkt_retry = 1'b0;
    chk("done_after_ack", done, 32'(exp_done));
    tick();
    chk("done_single", done, 0);
    chk("busy_after_ack", busy, 32'(!exp_done));
  endtask

  // Accepts one packet; checks count, data order, hold under backpressure, last-beat BE.
  task automatic collect(input string nm, input int seed, input int nb, input int w0,
                         input logic [3:0] lbe_exp, input bit zlp, input bit tog);
    int n, lat, bad, cyc;
    bit fin, held;
    logic [3:0] lbe, hb;
    logic [31:0] hd;
    logic hl;
    n = 0; lat = 0; bad = 0; cyc = 0; fin = 0; held = 0;
    lbe = 4'hF; hb = '0; hd = '0; hl = 1'b0;
    while (!fin && cyc < 2000) begin
      tx_ready = tog ? cyc[0] : 1'b1;
      if (tx_valid) begin
        if (held && (tx_data !== hd || tx_be !== hb || tx_last !== hl)) bad++;
        if (tx_ready) begin
          if (!zlp && tx_data !== wv(seed, w0 + n)) bad++;
          if (tx_last) begin lbe = tx_be; fin = 1'b1; end
          else if (tx_be !== 4'hF) bad++;
          n++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = tx_data; hb = tx_be; hl = tx_last;
        end
      end else if (n == 0) lat++;
      else bad++;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    chk({nm, "_finished"}, 32'(fin), 1);
    chk({nm, "_beats"}, n, nb);
    chk({nm, "_last_be"}, 32'(lbe), 32'(lbe_exp));
    chk({nm, "_bad_beats"}, bad, 0);
    chk({nm, "_latency"}, lat, 1);
    chk({nm, "_valid_after_last"}, tx_valid, 0);
  endtask

  initial begin
    int n;
    tv[0] = '{18,   64,   5,   5,   4'b0011, 0,   4'hF,    0, 0};
    tv[1] = '{512,  1024, 128, 128, 4'hF,    0,   4'hF,    1, 0};
    tv[2] = '{600,  600,  150, 128, 4'hF,    22,  4'hF,    0, 0};
    tv[3] = '{18,   8,    5,   2,   4'hF,    0,   4'hF,    0, 1};
    tv[4] = '{0,    64,   0,   0,   4'hF,    0,   4'hF,    1, 0};
    tv[5] = '{1100, 2000, 260, 128, 4'hF,    128, 4'hF,    1, 0};
    tv[6] = '{7,    7,    2,   2,   4'b0111, 0,   4'hF,    0, 1};
    tv[7] = '{513,  513,  129, 128, 4'hF,    1,   4'b0001, 0, 0};
    tv[8] = '{512,  512,  128, 128, 4'hF,    0,   4'hF,    0, 0};

    tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_be", tx_be, 0);
    chk("rst_ram_wr_we", ram_wr_we, 0);
    chk("rst_ram_rd_adr", ram_rd_adr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      load(v + 10, tv[v].nload);
      commit(tv[v].len, tv[v].wl);
      if (tv[v].p0 > 0) begin
        req();
        collect($sformatf("v%0d_p0", v), v + 10, tv[v].p0, 0, tv[v].b0, 1'b0, tv[v].tog);
        ack(1'b0, 1'b0, tv[v].p1 == 0 && !tv[v].zlp);
      end
      if (tv[v].p1 > 0) begin
        req();
        collect($sformatf("v%0d_p1", v), v + 10, tv[v].p1, tv[v].p0, tv[v].b1, 1'b0, tv[v].tog);
        ack(1'b0, 1'b0, !tv[v].zlp);
      end
      if (tv[v].zlp) begin
        req();
        collect($sformatf("v%0d_zlp", v), v + 10, 1, 0, 4'b0000, 1'b1, tv[v].tog);
        ack(1'b0, 1'b0, 1'b1);
      end
    end

    // Retry with ack in the same cycle: retry wins and the packet is resent.
    load(2, 150);
    commit(600, 600);
    buf_wr_en = 1'b1;
    #1;
    chk("wr_ignored_ready", ram_wr_we, 0);
    buf_wr_en = 1'b0;
    req();
    collect("retry_first", 2, 128, 0, 4'hF, 1'b0, 1'b0);
    req();
    tick();
    chk("in_req_ignored_wait_ack", tx_valid, 0);
    ack(1'b1, 1'b1, 1'b0);
    req();
    collect("retry_resend", 2, 128, 0, 4'hF, 1'b0, 1'b0);
    ack(1'b0, 1'b0, 1'b0);
    req();
    collect("retry_second", 2, 22, 128, 4'hF, 1'b0, 1'b0);
    ack(1'b0, 1'b0, 1'b1);

    // Abort at beat 40 of the first packet.
    load(3, 150);
    commit(600, 600);
    req();
    n = 0;
    for (int c = 0; c < 200 && n < 40; c++) begin
      if (tx_valid) n++;
      tick();
    end
    chk("abort_beats_before", n, 40);
    chk("abort_valid_before", tx_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    chk("abort_ack_ignored", done, 0);
    req();
    tick();
    chk("abort_in_req_ignored", tx_valid, 0);

    // Abort during LOAD, then a fresh load starting at word 0.
    load(7, 7);
    chk("load_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_busy", busy, 0);
    load(8, 3);
    commit(12, 12);
    req();
    collect("after_abort", 8, 3, 0, 4'hF, 1'b0, 1'b0);
    ack(1'b0, 1'b0, 1'b1);

    // Reset during LOAD.
    load(5, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_load_busy", busy, 0);
    chk("reset_load_valid", tx_valid, 0);
    chk("reset_load_done", done, 0);
    load(6, 3);
    commit(12, 12);
    req();
    collect("after_reset", 6, 3, 0, 4'hF, 1'b0, 1'b0);
    ack(1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
